// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Single-outstanding RV32I data-memory responder. One request is accepted at a
// time from IDLE, held for a fixed number of cycles (LATENCY), then the memory
// access is carried out on the edge that enters RESP. The response is held
// until the initiator takes it, after which the responder returns to IDLE.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit storage words (power of two, 16..65536)
//   LATENCY      cycles from request acceptance to response valid (1..15)
//
// Ports
//   clk          single clock, all state changes on the rising edge
//   rst          synchronous, active-high reset (memory contents kept)
//   req_valid    initiator presents a request
//   req_ready    responder can accept a request this cycle (IDLE, not in reset)
//   req_we       1 = store, 0 = load
//   req_funct3   RV32I load/store size/sign code
//   req_addr     byte address
//   req_wdata    store data, right-aligned
//   rsp_valid    response present (RESP state)
//   rsp_ready    initiator accepts the response
//   rsp_rdata    load result extended to 32 bits; 0 for stores and errors
//   rsp_err      request was misaligned, illegal or out of range
// -----------------------------------------------------------------------------
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // State and request registers
   // ---------------------------------------------------------------------------
   state_t      r_state;
   state_t      w_next;
   logic [3:0]  r_cnt;

   logic        r_we;
   logic [2:0]  r_funct3;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;

   logic [31:0] r_rdata;
   logic        r_err;

   logic [31:0] r_mem [DEPTH_WORDS];

   logic        w_accept;
   logic        w_enter_resp;

   // ---------------------------------------------------------------------------
   // Operation source. With LATENCY = 1 the access happens on the accepting
   // edge itself, before the request registers hold anything, so the live
   // request inputs are used while in IDLE and the latched copy otherwise.
   // ---------------------------------------------------------------------------
   logic        w_op_we;
   logic [2:0]  w_op_funct3;
   logic [31:0] w_op_addr;
   logic [31:0] w_op_wdata;

   always_comb begin
      if (r_state == IDLE) begin
         w_op_we     = req_we;
         w_op_funct3 = req_funct3;
         w_op_addr   = req_addr;
         w_op_wdata  = req_wdata;
      end else begin
         w_op_we     = r_we;
         w_op_funct3 = r_funct3;
         w_op_addr   = r_addr;
         w_op_wdata  = r_wdata;
      end
   end

   // ---------------------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------------------
   logic [1:0]       w_lane;
   logic [IDX_W-1:0] w_idx;
   logic             w_oor;

   assign w_lane = w_op_addr[1:0];
   assign w_idx  = w_op_addr[IDX_W+1:2];
   // Any set bit above the word index means addr[31:2] >= DEPTH_WORDS.
   assign w_oor  = |w_op_addr[31:IDX_W+2];

   // ---------------------------------------------------------------------------
   // Error classification
   // ---------------------------------------------------------------------------
   logic w_op_err;

   always_comb begin
      w_op_err = 1'b0;
      unique case (w_op_funct3)
         3'b000:  w_op_err = 1'b0;                      // byte
         3'b001:  w_op_err = w_lane[0];                 // halfword
         3'b010:  w_op_err = (w_lane != 2'b00);         // word
         3'b100:  w_op_err = w_op_we;                   // LBU only
         3'b101:  w_op_err = w_op_we | w_lane[0];       // LHU only
         default: w_op_err = 1'b1;                      // 011/110/111
      endcase
      if (w_oor) begin
         w_op_err = 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Load path: select lane(s) from the addressed word and extend
   // ---------------------------------------------------------------------------
   logic [31:0] w_word;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_ext;
   logic [31:0] w_load_data;

   assign w_word = r_mem[w_idx];

   always_comb begin
      w_byte = w_word[7:0];
      unique case (w_lane)
         2'd0: w_byte = w_word[7:0];
         2'd1: w_byte = w_word[15:8];
         2'd2: w_byte = w_word[23:16];
         2'd3: w_byte = w_word[31:24];
      endcase
   end

   assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];

   always_comb begin
      w_load_ext = '0;
      unique case (w_op_funct3)
         3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
         3'b010:  w_load_ext = w_word;
         3'b100:  w_load_ext = {24'd0, w_byte};
         3'b101:  w_load_ext = {16'd0, w_half};
         default: w_load_ext = '0;
      endcase
   end

   // Stores and errored requests always answer with zero data.
   assign w_load_data = (w_op_we || w_op_err) ? '0 : w_load_ext;

   // ---------------------------------------------------------------------------
   // Store path: byte-enable mask and lane-replicated write data
   // ---------------------------------------------------------------------------
   logic [3:0]  w_be;
   logic [31:0] w_wd;

   always_comb begin
      w_be = 4'b0000;
      w_wd = w_op_wdata;
      unique case (w_op_funct3[1:0])
         2'b00: begin
            w_be = 4'b0001 << w_lane;
            w_wd = {4{w_op_wdata[7:0]}};
         end
         2'b01: begin
            w_be = w_lane[1] ? 4'b1100 : 4'b0011;
            w_wd = {2{w_op_wdata[15:0]}};
         end
         2'b10: begin
            w_be = 4'b1111;
            w_wd = w_op_wdata;
         end
         default: begin
            w_be = 4'b0000;
            w_wd = w_op_wdata;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: next state and handshake outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      w_next    = r_state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      unique case (r_state)
         IDLE: begin
            req_ready = ~rst;
            if (req_valid && !rst) begin
               w_next = (LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (r_cnt == 4'd2) begin
               w_next = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   assign w_accept     = req_valid && req_ready;
   assign w_enter_resp = (w_next == RESP) && (r_state != RESP) && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Latency counter: loaded on accept, counts down while waiting.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         r_cnt <= 4'(LATENCY);
      end else if (r_state == WAIT) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   // Request capture; later changes on the request inputs are ignored.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_we     <= req_we;
         r_funct3 <= req_funct3;
         r_addr   <= req_addr;
         r_wdata  <= req_wdata;
      end
   end

   // Response registers are updated only on the RESP-entry edge and held
   // there until the handshake completes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else if (w_enter_resp) begin
         r_rdata <= w_load_data;
         r_err   <= w_op_err;
      end
   end

   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;

   // Storage is not reset. A store abandoned by reset never reaches here
   // because w_enter_resp is gated by rst.
   always_ff @(posedge clk) begin
      if (w_enter_resp && w_op_we && !w_op_err) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (w_be[i]) begin
               r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Main instance: LATENCY = 3, DEPTH_WORDS = 64, checked every cycle against a
// byte-array model of memory and a timing expectation derived from the accept
// edge. Second instance: LATENCY = 1, DEPTH_WORDS = 16, checked with literal
// expectations for the zero-wait path.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

   localparam int unsigned L  = 3;
   localparam int unsigned D  = 64;
   localparam int unsigned L1 = 1;
   localparam int unsigned D1 = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // main instance signals
   logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata, rsp_rdata;

   // LATENCY = 1 instance signals
   logic        d1_req_valid, d1_req_ready, d1_req_we, d1_rsp_valid, d1_rsp_ready, d1_rsp_err;
   logic [2:0]  d1_req_funct3;
   logic [31:0] d1_req_addr, d1_req_wdata, d1_rsp_rdata;

   dmem_responder #(.DEPTH_WORDS(D), .LATENCY(L)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err)
   );

   dmem_responder #(.DEPTH_WORDS(D1), .LATENCY(L1)) u_dut1 (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (d1_req_valid),
      .req_ready  (d1_req_ready),
      .req_we     (d1_req_we),
      .req_funct3 (d1_req_funct3),
      .req_addr   (d1_req_addr),
      .req_wdata  (d1_req_wdata),
      .rsp_valid  (d1_rsp_valid),
      .rsp_ready  (d1_rsp_ready),
      .rsp_rdata  (d1_rsp_rdata),
      .rsp_err    (d1_rsp_err)
   );

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   // ---------------------------------------------------------------------------
   // Memory model: plain byte array, little-endian
   // ---------------------------------------------------------------------------
   logic [7:0] mb [D*4];

   function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
      logic e;
      case (f3)
         3'd0:    e = 1'b0;
         3'd1:    e = (a % 2) != 0;
         3'd2:    e = (a % 4) != 0;
         3'd4:    e = we;
         3'd5:    e = we || ((a % 2) != 0);
         default: e = 1'b1;
      endcase
      if ((a / 4) >= D) e = 1'b1;
      return e;
   endfunction

   function automatic logic [31:0] model_rdata(input logic we, input logic [2:0] f3, input logic [31:0] a);
      logic [7:0]  b;
      logic [15:0] h;
      if (we || model_err(we, f3, a)) return 32'd0;
      b = mb[a];
      h = {mb[a+1], mb[a]};
      case (f3)
         3'd0:    return 32'($signed(b));
         3'd1:    return 32'($signed(h));
         3'd2:    return {mb[a+3], mb[a+2], mb[a+1], mb[a]};
         3'd4:    return {24'd0, b};
         3'd5:    return {16'd0, h};
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_write(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      int unsigned n;
      n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
      for (int unsigned i = 0; i < n; i++) mb[a+i] = wd[8*i +: 8];
   endtask

   // ---------------------------------------------------------------------------
   // Expected response state and per-cycle compare process (main instance)
   // ---------------------------------------------------------------------------
   logic        cmp_en   = 1'b0;
   logic        exp_busy = 1'b0;
   int unsigned exp_due  = 0;
   logic [31:0] exp_rdata = '0;
   logic        exp_err   = 1'b0;

   always @(negedge clk) begin
      if (cmp_en) begin
         if (exp_busy) begin
            chk("busy_req_ready", 32'(req_ready), 32'd0);
            if (cyc < exp_due) begin
               chk("early_rsp_valid", 32'(rsp_valid), 32'd0);
            end else begin
               chk("rsp_valid", 32'(rsp_valid), 32'd1);
               chk("rsp_rdata", rsp_rdata, exp_rdata);
               chk("rsp_err", 32'(rsp_err), 32'(exp_err));
            end
         end else begin
            chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("idle_req_ready", 32'(req_ready), 32'(!rst));
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Directed vectors
   // ---------------------------------------------------------------------------
   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      int unsigned hold;
      logic        pulse;
      logic [31:0] rd;
      logic        err;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input int unsigned hold, input logic pulse,
                      input logic [31:0] rd, input logic err);
      vec_t v;
      v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd;
      v.hold = hold; v.pulse = pulse; v.rd = rd; v.err = err;
      vecs.push_back(v);
   endtask

   // One transaction on the main instance. abort = assert reset one cycle
   // after the accepting edge instead of completing.
   task automatic txn(input vec_t v, input logic abort);
      int unsigned t;
      logic [31:0] r;
      logic        e;
      @(negedge clk);
      req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
      req_valid = 1'b1;
      t = 0;
      while (!req_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!req_ready) begin
         chk("accept_timeout", 32'(req_ready), 32'd1);
         req_valid = 1'b0;
         return;
      end
      e = model_err(v.we, v.f3, v.addr);
      r = model_rdata(v.we, v.f3, v.addr);
      chk("model_pin_rdata", r, v.rd);
      chk("model_pin_err", 32'(e), 32'(v.err));
      @(posedge clk);
      #1;
      exp_rdata = r;
      exp_err   = e;
      exp_due   = cyc + L - 1;
      exp_busy  = 1'b1;
      // request inputs change after acceptance and must not matter
      req_valid  = 1'b0;
      req_we     = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      if (abort) begin
         rst = 1'b1;
         @(posedge clk);
         #1;
         exp_busy = 1'b0;
         chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
         chk("abort_rsp_rdata", rsp_rdata, 32'd0);
         chk("abort_rsp_err", 32'(rsp_err), 32'd0);
         chk("abort_req_ready", 32'(req_ready), 32'd0);
         @(negedge clk);
         rst = 1'b0;
         return;
      end
      t = 0;
      while (cyc < exp_due && t < 20) begin
         @(negedge clk);
         t++;
      end
      for (int unsigned i = 0; i < v.hold; i++) begin
         if (v.pulse && i == 1) begin
            req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
            req_addr = 32'h10; req_wdata = 32'h0BAD0BAD;
         end
         @(negedge clk);
         req_valid = 1'b0;
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      exp_busy  = 1'b0;
      if (v.we && !e) model_write(v.f3, v.addr, v.wdata);
   endtask

   // Transaction on the LATENCY = 1 instance with literal expectations.
   task automatic txn1(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input logic err);
      @(negedge clk);
      d1_req_we = we; d1_req_funct3 = f3; d1_req_addr = a; d1_req_wdata = wd;
      d1_req_valid = 1'b1;
      chk("l1_pre_rsp_valid", 32'(d1_rsp_valid), 32'd0);
      chk("l1_req_ready", 32'(d1_req_ready), 32'd1);
      @(posedge clk);
      #1;
      d1_req_valid = 1'b0;
      d1_req_addr  = $urandom;
      d1_req_wdata = $urandom;
      chk("l1_rsp_valid", 32'(d1_rsp_valid), 32'd1);
      chk("l1_rsp_rdata", d1_rsp_rdata, rd);
      chk("l1_rsp_err", 32'(d1_rsp_err), 32'(err));
      d1_rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      d1_rsp_ready = 1'b0;
      chk("l1_post_rsp_valid", 32'(d1_rsp_valid), 32'd0);
   endtask

   initial begin
      vec_t v;
      for (int unsigned i = 0; i < D*4; i++) mb[i] = 8'h00;
      rst = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;
      rsp_ready = 1'b0;
      d1_req_valid = 1'b0; d1_req_we = 1'b0; d1_req_funct3 = 3'd0;
      d1_req_addr = '0; d1_req_wdata = '0; d1_rsp_ready = 1'b0;

      //   we  f3    addr        wdata         hold pulse  rdata         err
      add(1, 3'd2, 32'h10,  32'hDEADBEEF, 0, 0, 32'h00000000, 0);
      add(0, 3'd2, 32'h10,  32'h0,        2, 0, 32'hDEADBEEF, 0);
      add(1, 3'd0, 32'h11,  32'h000000A5, 0, 0, 32'h00000000, 0);
      add(0, 3'd0, 32'h11,  32'h0,        0, 0, 32'hFFFFFFA5, 0);
      add(0, 3'd4, 32'h11,  32'h0,        0, 0, 32'h000000A5, 0);
      add(0, 3'd2, 32'h10,  32'h0,        0, 0, 32'hDEADA5EF, 0);
      add(0, 3'd1, 32'h13,  32'h0,        0, 0, 32'h00000000, 1);
      add(0, 3'd2, 32'h100, 32'h0,        0, 0, 32'h00000000, 1);
      add(0, 3'd2, 32'h10,  32'h0,        0, 0, 32'hDEADA5EF, 0);
      add(1, 3'd1, 32'h16,  32'hFFFFBEEF, 0, 0, 32'h00000000, 0);
      add(0, 3'd5, 32'h16,  32'h0,        0, 0, 32'h0000BEEF, 0);
      add(0, 3'd1, 32'h16,  32'h0,        1, 0, 32'hFFFFBEEF, 0);
      add(1, 3'd3, 32'h10,  32'h0,        0, 0, 32'h00000000, 1);
      add(1, 3'd4, 32'h10,  32'h0,        0, 0, 32'h00000000, 1);
      add(1, 3'd2, 32'h12,  32'h0,        0, 0, 32'h00000000, 1);
      add(1, 3'd2, 32'h104, 32'h0,        0, 0, 32'h00000000, 1);
      add(0, 3'd5, 32'h10,  32'h0,        0, 0, 32'h0000A5EF, 0);
      add(0, 3'd0, 32'h12,  32'h0,        0, 0, 32'hFFFFFFAD, 0);
      add(0, 3'd2, 32'h10,  32'h0,        5, 1, 32'hDEADA5EF, 0);
      add(0, 3'd2, 32'h10,  32'h0,        0, 0, 32'hDEADA5EF, 0);

      repeat (3) @(posedge clk);
      #1;
      cmp_en = 1'b1;
      chk("reset_rsp_rdata", rsp_rdata, 32'd0);
      chk("reset_rsp_err", 32'(rsp_err), 32'd0);
      chk("reset_l1_rsp_valid", 32'(d1_rsp_valid), 32'd0);
      chk("reset_l1_req_ready", 32'(d1_req_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) txn(vecs[i], 1'b0);

      // store abandoned by reset must never land
      v.we = 1; v.f3 = 3'd2; v.addr = 32'h20; v.wdata = 32'hCAFEF00D;
      v.hold = 0; v.pulse = 0; v.rd = 32'h0; v.err = 0;
      txn(v, 1'b0);
      v.wdata = 32'h12345678;
      txn(v, 1'b1);
      repeat (2) @(negedge clk);
      v.we = 0; v.wdata = 32'h0; v.rd = 32'hCAFEF00D;
      txn(v, 1'b0);

      // zero-wait instance
      txn1(1, 3'd2, 32'h8, 32'h11223344, 32'h00000000, 0);
      txn1(0, 3'd2, 32'h8, 32'h0,        32'h11223344, 0);
      txn1(0, 3'd0, 32'hB, 32'h0,        32'h00000011, 0);
      txn1(0, 3'd2, 32'h40, 32'h0,       32'h00000000, 1);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
